// File: rtl/fpu_mul_core.sv
// fpu_mul_core: sequential IEEE-754 binary32 multiplier, fixed 27-cycle latency.
// Flush-to-zero on exponent-0 inputs, round toward zero, single quiet NaN.
//   clk     in   rising-edge clock
//   rst     in   synchronous active-high reset
//   start   in   request, sampled only in idle
//   op_a    in   operand A (captured on accepted start)
//   op_b    in   operand B (captured on accepted start)
//   busy    out  operation in flight (unpack, multiply, normalise)
//   done    out  one-cycle pulse, result/flags valid from this cycle
//   result  out  binary32 product, held until overwritten
//   flags   out  {invalid, overflow, underflow, inexact}
module fpu_mul_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [3:0]  flags
);

    typedef enum logic [2:0] {StIdle, StUnpack, StMul, StNorm, StDone} state_e;

    localparam logic [31:0] QNan = 32'h7FC0_0000;

    state_e             state_q, state_d;
    logic [31:0]        a_q, a_d, b_q, b_d;
    logic               sign_q, sign_d;
    logic signed [9:0]  exp_q, exp_d;
    logic [47:0]        mcand_q, mcand_d;
    logic [23:0]        mplier_q, mplier_d;
    logic [47:0]        prod_q, prod_d;
    logic [4:0]         cnt_q, cnt_d;
    logic               spec_q, spec_d;
    logic [31:0]        spec_res_q, spec_res_d;
    logic [3:0]         spec_flags_q, spec_flags_d;
    logic [31:0]        result_q, result_d;
    logic [3:0]         flags_q, flags_d;
    logic               done_q, done_d;

    // Operand classification on the captured operands.
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;

    assign ea     = a_q[30:23];
    assign eb     = b_q[30:23];
    assign fa     = a_q[22:0];
    assign fb     = b_q[22:0];
    assign nan_a  = (ea == 8'hFF) && (fa != 23'd0);
    assign nan_b  = (eb == 8'hFF) && (fb != 23'd0);
    assign inf_a  = (ea == 8'hFF) && (fa == 23'd0);
    assign inf_b  = (eb == 8'hFF) && (fb == 23'd0);
    assign zero_a = (ea == 8'h00); // denormals flushed
    assign zero_b = (eb == 8'h00);

    // Normalisation of the finished product.
    logic signed [9:0] norm_exp;
    logic [22:0]       norm_frac;
    logic              norm_lost;

    always_comb begin
        norm_exp  = exp_q;
        norm_frac = prod_q[45:23];
        norm_lost = |prod_q[22:0];
        if (prod_q[47]) begin
            norm_exp  = exp_q + 10'sd1;
            norm_frac = prod_q[46:24];
            norm_lost = |prod_q[23:0];
        end
    end

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        sign_d       = sign_q;
        exp_d        = exp_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        prod_d       = prod_q;
        cnt_d        = cnt_q;
        spec_d       = spec_q;
        spec_res_d   = spec_res_q;
        spec_flags_d = spec_flags_q;
        result_d     = result_q;
        flags_d      = flags_q;
        done_d       = (state_q == StDone);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    state_d = StUnpack;
                end
            end
            StUnpack: begin
                sign_d   = a_q[31] ^ b_q[31];
                exp_d    = signed'({2'b00, ea}) + signed'({2'b00, eb}) - 10'sd127;
                mcand_d  = {24'd0, 1'b1, fa};
                mplier_d = {1'b1, fb};
                prod_d   = 48'd0;
                cnt_d    = 5'd0;
                spec_d   = 1'b1;
                if (nan_a || nan_b) begin
                    spec_res_d   = QNan;
                    spec_flags_d = 4'b1000;
                end else if ((inf_a && zero_b) || (zero_a && inf_b)) begin
                    spec_res_d   = QNan;
                    spec_flags_d = 4'b1000;
                end else if (inf_a || inf_b) begin
                    spec_res_d   = {a_q[31] ^ b_q[31], 8'hFF, 23'd0};
                    spec_flags_d = 4'b0000;
                end else if (zero_a || zero_b) begin
                    spec_res_d   = {a_q[31] ^ b_q[31], 31'd0};
                    spec_flags_d = 4'b0000;
                end else begin
                    spec_d       = 1'b0;
                    spec_res_d   = 32'd0;
                    spec_flags_d = 4'b0000;
                end
                state_d = StMul;
            end
            StMul: begin
                // One multiplier bit per cycle, LSB first.
                if (mplier_q[0]) begin
                    prod_d = prod_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'd23) begin
                    state_d = StNorm;
                end
            end
            StNorm: begin
                if (spec_q) begin
                    result_d = spec_res_q;
                    flags_d  = spec_flags_q;
                end else if (norm_exp >= 10'sd255) begin
                    result_d = {sign_q, 8'hFF, 23'd0};
                    flags_d  = 4'b0101;
                end else if (norm_exp <= 10'sd0) begin
                    result_d = {sign_q, 31'd0};
                    flags_d  = {3'b001, |prod_q};
                end else begin
                    result_d = {sign_q, norm_exp[7:0], norm_frac};
                    flags_d  = {3'b000, norm_lost};
                end
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            a_q          <= 32'd0;
            b_q          <= 32'd0;
            sign_q       <= 1'b0;
            exp_q        <= 10'sd0;
            mcand_q      <= 48'd0;
            mplier_q     <= 24'd0;
            prod_q       <= 48'd0;
            cnt_q        <= 5'd0;
            spec_q       <= 1'b0;
            spec_res_q   <= 32'd0;
            spec_flags_q <= 4'd0;
            result_q     <= 32'd0;
            flags_q      <= 4'd0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sign_q       <= sign_d;
            exp_q        <= exp_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            prod_q       <= prod_d;
            cnt_q        <= cnt_d;
            spec_q       <= spec_d;
            spec_res_q   <= spec_res_d;
            spec_flags_q <= spec_flags_d;
            result_q     <= result_d;
            flags_q      <= flags_d;
            done_q       <= done_d;
        end
    end

    // done is registered off the DONE state, so it lands in the idle cycle after it.
    assign busy   = (state_q == StUnpack) || (state_q == StMul) || (state_q == StNorm);
    assign done   = done_q;
    assign result = result_q;
    assign flags  = flags_q;

endmodule

// File: tb/tb_fpu_mul_core.sv
module tb_fpu_mul_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] op_a, op_b;
    logic        busy, done;
    logic [31:0] result;
    logic [3:0]  flags;

    int checks = 0;
    int errors = 0;

    fpu_mul_core dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .flags  (flags)
    );

    always #5 clk = ~clk;

    // Reference arithmetic straight from the binary32 rules (FTZ, truncation).
    function automatic void fmul(input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic [3:0] f);
        logic        s;
        int          ea, eb, e;
        logic [22:0] fa, fb;
        longint unsigned p, frac, lost;
        bit nan_a, nan_b, inf_a, inf_b, z_a, z_b;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = a[22:0];
        fb = b[22:0];
        nan_a = (ea == 255) && (fa != 0);
        nan_b = (eb == 255) && (fb != 0);
        inf_a = (ea == 255) && (fa == 0);
        inf_b = (eb == 255) && (fb == 0);
        z_a   = (ea == 0);
        z_b   = (eb == 0);
        if (nan_a || nan_b || (inf_a && z_b) || (z_a && inf_b)) begin
            r = 32'h7FC0_0000; f = 4'b1000;
        end else if (inf_a || inf_b) begin
            r = {s, 8'hFF, 23'd0}; f = 4'b0000;
        end else if (z_a || z_b) begin
            r = {s, 31'd0}; f = 4'b0000;
        end else begin
            p = (64'd8388608 + 64'(fa)) * (64'd8388608 + 64'(fb));
            e = ea + eb - 127;
            if (p >= 64'd140737488355328) begin // 2^47
                e    = e + 1;
                frac = (p / 64'd16777216) % 64'd8388608;
                lost = p % 64'd16777216;
            end else begin
                frac = (p / 64'd8388608) % 64'd8388608;
                lost = p % 64'd8388608;
            end
            if (e >= 255) begin
                r = {s, 8'hFF, 23'd0}; f = 4'b0101;
            end else if (e <= 0) begin
                r = {s, 31'd0}; f = 4'b0011;
            end else begin
                r = {s, 8'(e), 23'(frac)}; f = {3'b000, lost != 0};
            end
        end
    endfunction

    // Timing model: age = edges since the accepting edge, -1 when nothing in flight.
    int          m_age = -1;
    logic [31:0] m_pend_r, m_res = 32'd0;
    logic [3:0]  m_pend_f, m_flags = 4'd0;
    bit          cmp_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_age   = -1;
            m_res   = 32'd0;
            m_flags = 4'd0;
        end else begin
            if ((m_age < 0 || m_age >= 27) && start) begin
                fmul(op_a, op_b, m_pend_r, m_pend_f);
                m_age = 0;
            end else if (m_age >= 0) begin
                m_age = (m_age >= 27) ? -1 : m_age + 1;
            end
            if (m_age == 26) begin
                m_res   = m_pend_r;
                m_flags = m_pend_f;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic exp_busy, exp_done;
            exp_busy = (m_age >= 0) && (m_age <= 25);
            exp_done = (m_age == 27);
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL busy t=%0t got %b want %b", $time, busy, exp_busy);
            end
            checks++;
            if (done !== exp_done) begin
                errors++;
                $display("FAIL done t=%0t got %b want %b", $time, done, exp_done);
            end
            checks++;
            if (result !== m_res || flags !== m_flags) begin
                errors++;
                $display("FAIL result t=%0t got %h/%b want %h/%b", $time, result, flags,
                         m_res, m_flags);
            end
        end
    end

    task automatic run_vec(input logic [31:0] a, input logic [31:0] b, input logic [31:0] er,
                           input logic [3:0] ef, input string nm, input bit from_reset);
        logic [31:0] mr;
        logic [3:0]  mf;
        int          lat;
        fmul(a, b, mr, mf);
        checks++;
        if (mr !== er || mf !== ef) begin
            errors++;
            $display("FAIL model_%s got %h/%b want %h/%b", nm, mr, mf, er, ef);
        end
        if (!from_reset) @(negedge clk);
        rst   = 1'b0;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat != 27) begin
            errors++;
            $display("FAIL latency_%s got %0d want 27", nm, lat);
        end
        checks++;
        if (result !== er || flags !== ef) begin
            errors++;
            $display("FAIL dut_%s got %h/%b want %h/%b", nm, result, flags, er, ef);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int ndone, lat;
        rst   = 1'b1;
        start = 1'b0;
        op_a  = 32'd0;
        op_b  = 32'd0;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || flags !== 4'd0) begin
            errors++;
            $display("FAIL reset got busy=%b done=%b %h/%b want 0 0 00000000/0000",
                     busy, done, result, flags);
        end

        run_vec(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 4'b0000, "basic", 1'b1);
        run_vec(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 4'b0000, "norm", 1'b0);
        run_vec(32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000, 4'b0000, "sign", 1'b0);
        run_vec(32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 4'b0001, "inexact", 1'b0);
        run_vec(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000, "infzero", 1'b0);
        run_vec(32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 4'b0101, "overflow", 1'b0);
        run_vec(32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 4'b0011, "underflow", 1'b0);
        run_vec(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'b1000, "nan", 1'b0);
        run_vec(32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, 4'b0000, "inf_neg", 1'b0);
        run_vec(32'h8000_0000, 32'h4040_0000, 32'h8000_0000, 4'b0000, "neg_zero", 1'b0);
        run_vec(32'h0000_0001, 32'h4000_0000, 32'h0000_0000, 4'b0000, "denorm", 1'b0);
        run_vec(32'h4000_0000, 32'h3F00_0000, 32'h3F80_0000, 4'b0000, "half", 1'b0);

        // Start re-pulsed with different operands while busy: must be ignored.
        @(negedge clk);
        op_a  = 32'h4000_0000;
        op_b  = 32'h4040_0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        lat   = -1;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            if (i == 5) begin
                start = 1'b1;
                op_a  = 32'h3FC0_0000;
                op_b  = 32'h3FC0_0000;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                lat = i;
            end
        end
        checks++;
        if (ndone != 1 || lat != 27) begin
            errors++;
            $display("FAIL busy_start got %0d pulses at %0d want 1 at 27", ndone, lat);
        end
        checks++;
        if (result !== 32'h40C0_0000 || flags !== 4'b0000) begin
            errors++;
            $display("FAIL busy_start_result got %h/%b want 40c00000/0000", result, flags);
        end

        // Reset sampled on the tenth edge after the accepting edge aborts the operation.
        op_a  = 32'h3F80_0001;
        op_b  = 32'h3F80_0001;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || result !== 32'd0 || flags !== 4'd0) begin
            errors++;
            $display("FAIL abort got busy=%b %h/%b want 0 00000000/0000", busy, result, flags);
        end
        rst   = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL abort_done got %0d pulses want 0", ndone);
        end

        // start held high: operations back to back every 28 cycles.
        op_a  = 32'h3FC0_0000;
        op_b  = 32'h3FC0_0000;
        start = 1'b1;
        ndone = 0;
        repeat (60) begin
            @(negedge clk);
            if (done) ndone++;
        end
        start = 1'b0;
        checks++;
        if (ndone != 2) begin
            errors++;
            $display("FAIL back_to_back got %0d pulses want 2", ndone);
        end
        repeat (40) @(negedge clk);
        checks++;
        if (result !== 32'h4010_0000 || flags !== 4'b0000) begin
            errors++;
            $display("FAIL back_to_back_result got %h/%b want 40100000/0000", result, flags);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
